// File: rtl/dds_pkg.sv
// Shared types, constants and helpers for the quarter-wave DDS phase sequencer.
package dds_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  localparam int LUT_AW = 6;

  localparam logic [1:0] Q0 = 2'd0;
  localparam logic [1:0] Q1 = 2'd1;
  localparam logic [1:0] Q2 = 2'd2;
  localparam logic [1:0] Q3 = 2'd3;

  // Second and fourth quadrants walk the quarter-wave table backwards.
  function automatic logic [LUT_AW-1:0] mirror(input logic [LUT_AW-1:0] idx);
    return {LUT_AW{1'b1}} - idx;
  endfunction

endpackage

// File: rtl/dds_quad_map.sv
// Quadrant decode: folds the top phase bits onto a quarter-wave LUT address
// plus a negate flag for the lower half of the sine.
module dds_quad_map
  import dds_pkg::*;
(
  input  logic [1:0]        quad_i,
  input  logic [LUT_AW-1:0] idx_i,
  output logic [LUT_AW-1:0] addr_o,
  output logic              neg_o
);

  always_comb begin
    addr_o = idx_i;
    neg_o  = 1'b0;
    case (quad_i)
      Q0: begin
        addr_o = idx_i;
        neg_o  = 1'b0;
      end
      Q1: begin
        addr_o = mirror(idx_i);
        neg_o  = 1'b0;
      end
      Q2: begin
        addr_o = idx_i;
        neg_o  = 1'b1;
      end
      Q3: begin
        addr_o = mirror(idx_i);
        neg_o  = 1'b1;
      end
      default: begin
        addr_o = idx_i;
        neg_o  = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/dds_phase_ctrl.sv
// Phase-accumulator sequencer for the quarter-wave sine DDS: drives LUT address,
// negate and sample strobe, runs continuous or counted bursts, glitch-free FTW updates.
module dds_phase_ctrl
  import dds_pkg::*;
#(
  parameter int ACC_W = 16,
  parameter int CNT_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              stop,
  input  logic [CNT_W-1:0]  burst_len,
  input  logic [ACC_W-1:0]  ftw_in,
  input  logic              ftw_valid,
  output logic              ftw_ready,
  output logic [LUT_AW-1:0] lut_addr,
  output logic              lut_neg,
  output logic              lut_en,
  output logic              period_tick,
  output logic              busy,
  output logic              done
);

  state_e           state_q, state_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [ACC_W-1:0] ftw_act_q, ftw_act_d;
  logic [ACC_W-1:0] pend_q;
  logic             pend_valid_q, pend_valid_d;
  logic             stop_pend_q, stop_pend_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             done_q, done_d;

  logic [ACC_W:0]    sum;
  logic              run;
  logic              wrap;
  logic              xfer;
  logic              end_now;
  logic [LUT_AW-1:0] map_addr;
  logic              map_neg;

  assign run  = (state_q == RUN);
  assign sum  = {1'b0, acc_q} + {1'b0, ftw_act_q};
  assign wrap = run & sum[ACC_W];
  assign ftw_ready = ~pend_valid_q;
  assign xfer = ftw_valid & ftw_ready;

  // A zero tuning word never wraps, so a pending stop must not wait for one.
  assign end_now = (wrap && (stop_pend_q || (cnt_q == CNT_W'(1)))) ||
                   (run && (ftw_act_q == '0) && stop_pend_q);

  always_comb begin
    state_d      = state_q;
    acc_d        = acc_q;
    ftw_act_d    = ftw_act_q;
    pend_valid_d = pend_valid_q;
    stop_pend_d  = stop_pend_q;
    cnt_d        = cnt_q;
    done_d       = 1'b0;
    case (state_q)
      IDLE: begin
        acc_d = '0;
        if (xfer) begin
          ftw_act_d = ftw_in;
        end
        if (start) begin
          state_d     = RUN;
          cnt_d       = burst_len;
          stop_pend_d = 1'b0;
        end
      end
      RUN: begin
        acc_d = sum[ACC_W-1:0];
        if (stop) begin
          stop_pend_d = 1'b1;
        end
        if (xfer) begin
          pend_valid_d = 1'b1;
        end
        if (end_now) begin
          state_d     = IDLE;
          acc_d       = '0;
          stop_pend_d = 1'b0;
          done_d      = 1'b1;
        end else if (wrap) begin
          if (cnt_q != '0) begin
            cnt_d = cnt_q - CNT_W'(1);
          end
          // New word only takes effect on a period boundary.
          if (pend_valid_q) begin
            ftw_act_d    = pend_q;
            pend_valid_d = 1'b0;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      acc_q        <= '0;
      ftw_act_q    <= '0;
      pend_valid_q <= 1'b0;
      stop_pend_q  <= 1'b0;
      cnt_q        <= '0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      acc_q        <= acc_d;
      ftw_act_q    <= ftw_act_d;
      pend_valid_q <= pend_valid_d;
      stop_pend_q  <= stop_pend_d;
      cnt_q        <= cnt_d;
      done_q       <= done_d;
    end
  end

  // Holding register is qualified by pend_valid_q, so it needs no reset.
  always_ff @(posedge clk) begin
    if (run && xfer) begin
      pend_q <= ftw_in;
    end
  end

  dds_quad_map u_quad_map (
    .quad_i (acc_q[ACC_W-1 -: 2]),
    .idx_i  (acc_q[ACC_W-3 -: LUT_AW]),
    .addr_o (map_addr),
    .neg_o  (map_neg)
  );

  assign lut_addr    = run ? map_addr : '0;
  assign lut_neg     = run & map_neg;
  assign lut_en      = run;
  assign busy        = run;
  assign period_tick = wrap;
  assign done        = done_q;

endmodule

// File: tb/tb_dds_phase_ctrl.sv
// Scoreboard bench for dds_phase_ctrl: a phase/period-level model predicts every
// running sample and every done pulse; a negedge monitor pops and compares.
module tb_dds_phase_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic        stop = 1'b0;
  logic [7:0]  burst_len = '0;
  logic [15:0] ftw_in = '0;
  logic        ftw_valid = 1'b0;
  logic        ftw_ready;
  logic [5:0]  lut_addr;
  logic        lut_neg;
  logic        lut_en;
  logic        period_tick;
  logic        busy;
  logic        done;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  int smp_cnt  = 0;
  int tick_cnt = 0;

  typedef struct {
    int addr;
    bit neg;
    bit tick;
    bit rdy;
  } smp_t;

  smp_t exp_q[$];
  int   done_q[$];

  // Reference model state: phase in [0,65536), active step, one-deep pending word.
  bit m_run, m_has_pend, m_stop_req;
  int m_phase, m_freq, m_pend, m_left;

  dds_phase_ctrl #(.ACC_W(16), .CNT_W(8)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .stop        (stop),
    .burst_len   (burst_len),
    .ftw_in      (ftw_in),
    .ftw_valid   (ftw_valid),
    .ftw_ready   (ftw_ready),
    .lut_addr    (lut_addr),
    .lut_neg     (lut_neg),
    .lut_en      (lut_en),
    .period_tick (period_tick),
    .busy        (busy),
    .done        (done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic model_reset();
    m_run = 0; m_has_pend = 0; m_stop_req = 0;
    m_phase = 0; m_freq = 0; m_pend = 0; m_left = 0;
    exp_q.delete();
    done_q.delete();
  endtask

  // Predict this cycle's outputs, then advance one clock under the given inputs.
  task automatic model_step(input bit st, input bit sp, input int bl, input bit fv, input int fw);
    bit accept, wraps, finish;
    int pos, quad, idx;
    smp_t s;
    accept = fv && !m_has_pend;
    if (m_run) begin
      wraps  = (m_phase + m_freq) >= 65536;
      pos    = m_phase / 256;
      quad   = pos / 64;
      idx    = pos % 64;
      s.addr = (quad % 2 == 1) ? 63 - idx : idx;
      s.neg  = (quad >= 2);
      s.tick = wraps;
      s.rdy  = !m_has_pend;
      exp_q.push_back(s);
      finish = (wraps && (m_stop_req || m_left == 1)) || (m_freq == 0 && m_stop_req);
      if (sp) m_stop_req = 1;
      if (finish) begin
        m_run = 0; m_phase = 0; m_stop_req = 0;
        done_q.push_back(cyc + 1);
      end else begin
        m_phase = (m_phase + m_freq) % 65536;
        if (wraps) begin
          if (m_left > 0) m_left--;
          if (m_has_pend) begin
            m_freq = m_pend;
            m_has_pend = 0;
          end
        end
      end
      if (accept) begin
        m_pend = fw;
        m_has_pend = 1;
      end
    end else begin
      if (accept) m_freq = fw;
      if (st) begin
        m_run = 1; m_phase = 0; m_left = bl; m_stop_req = 0;
      end
    end
  endtask

  task automatic tick_cyc(input bit st, input bit sp, input int bl, input bit fv, input int fw);
    start = st; stop = sp; burst_len = 8'(bl); ftw_valid = fv; ftw_in = 16'(fw);
    model_step(st, sp, bl, fv, fw);
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick_cyc(0, 0, 0, 0, 0);
  endtask

  task automatic wait_idle(input string name, input int budget);
    int k;
    k = 0;
    while ((busy || m_run) && k < budget) begin
      tick_cyc(0, 0, 0, 0, 0);
      k++;
    end
    chk(name, busy, 0);
  endtask

  // Monitor: compares whenever the DUT presents a sample or a done pulse.
  always @(negedge clk) begin : monitor
    smp_t s;
    if (rst) begin
      if (lut_en) begin
        smp_cnt++;
        if (period_tick) tick_cnt++;
        if (exp_q.size() == 0) chk("lut_en_unexpected", lut_en, 0);
        else begin
          s = exp_q.pop_front();
          chk("lut_addr", lut_addr, s.addr);
          chk("lut_neg", lut_neg, s.neg);
          chk("period_tick", period_tick, s.tick);
          chk("ftw_ready_run", ftw_ready, s.rdy);
          chk("busy_run", busy, 1);
        end
      end else begin
        chk("idle_addr", lut_addr, 0);
        chk("idle_neg", lut_neg, 0);
        chk("idle_tick", period_tick, 0);
        chk("idle_busy", busy, 0);
      end
      if (done_q.size() > 0 && done_q[0] < cyc) begin
        chk("done_missing", done, 1);
        void'(done_q.pop_front());
      end
      if (done) begin
        if (done_q.size() == 0) chk("done_unexpected", done, 0);
        else chk("done_cycle", cyc, done_q.pop_front());
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int c0, t0, w, bl;
    bit fv, sp, st;
    model_reset();
    repeat (2) @(posedge clk);
    #2;
    chk("rst_lut_en", lut_en, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_addr", lut_addr, 0);
    chk("rst_neg", lut_neg, 0);
    chk("rst_tick", period_tick, 0);
    chk("rst_ready", ftw_ready, 1);
    rst = 1'b1;
    @(posedge clk); #1;

    // Continuous tone, step 4 address units per cycle.
    tick_cyc(0, 0, 0, 1, 16'h0400);
    tick_cyc(1, 0, 0, 0, 0);
    t0 = tick_cnt;
    idle(256);
    chk("cont_ticks_256", tick_cnt - t0, 4);
    // Graceful stop mid-period.
    idle(20);
    tick_cyc(0, 1, 0, 0, 0);
    wait_idle("stop_to_idle", 100);
    idle(3);

    // Two-period burst.
    tick_cyc(0, 0, 0, 1, 16'h0400);
    c0 = smp_cnt; t0 = tick_cnt;
    tick_cyc(1, 0, 2, 0, 0);
    wait_idle("burst_to_idle", 400);
    idle(3);
    chk("burst_samples", smp_cnt - c0, 128);
    chk("burst_ticks", tick_cnt - t0, 2);

    // Tuning update mid-period lands only at the wrap.
    tick_cyc(1, 0, 0, 0, 0);
    idle(10);
    tick_cyc(0, 0, 0, 1, 16'h0800);
    chk("upd_ready_low", ftw_ready, 0);
    idle(60);
    chk("upd_ready_back", ftw_ready, 1);
    idle(40);
    tick_cyc(0, 1, 0, 0, 0);
    wait_idle("upd_to_idle", 100);
    idle(2);

    // Zero tuning word: no wrap ever, stop acts on the following edge.
    tick_cyc(0, 0, 0, 1, 0);
    tick_cyc(1, 0, 0, 0, 0);
    idle(10);
    tick_cyc(0, 1, 0, 0, 0);
    wait_idle("zero_ftw_stop", 4);
    idle(2);

    // Async reset mid-burst with a word pending.
    tick_cyc(0, 0, 0, 1, 16'h0400);
    tick_cyc(1, 0, 5, 0, 0);
    idle(10);
    tick_cyc(0, 0, 0, 1, 16'h1000);
    chk("pend_ready_low", ftw_ready, 0);
    idle(8);
    start = 0; stop = 0; ftw_valid = 0;
    model_step(0, 0, 0, 0, 0);
    #6;
    rst = 1'b0;
    #1;
    chk("arst_lut_en", lut_en, 0);
    chk("arst_busy", busy, 0);
    chk("arst_addr", lut_addr, 0);
    chk("arst_done", done, 0);
    chk("arst_ready", ftw_ready, 1);
    model_reset();
    @(posedge clk); #3;
    rst = 1'b1;
    @(posedge clk); #1;
    idle(5);
    // Active word was cleared by reset: tone sits at address 0.
    tick_cyc(1, 0, 0, 0, 0);
    idle(6);
    tick_cyc(0, 1, 0, 0, 0);
    wait_idle("post_rst_stop", 4);
    idle(2);

    // Randomized bursts, tuning updates, stray starts and stops.
    for (int r = 0; r < 8; r++) begin
      w  = $urandom_range(16'h0800, 16'h2000);
      bl = $urandom_range(0, 3);
      tick_cyc(0, 0, 0, 1, w);
      tick_cyc(1, 0, bl, 0, 0);
      for (int k = 0; k < 300 && m_run; k++) begin
        fv = ($urandom_range(0, 7) == 0);
        sp = (bl == 0) && ($urandom_range(0, 99) == 0);
        st = ($urandom_range(0, 15) == 0);
        tick_cyc(st, sp, $urandom_range(0, 255), fv, $urandom_range(16'h0400, 16'h3000));
      end
      if (m_run) tick_cyc(0, 1, 0, 0, 0);
      wait_idle("rand_to_idle", 300);
      idle(2);
    end

    idle(3);
    chk("exp_q_drained", exp_q.size(), 0);
    chk("done_q_drained", done_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/dds_phase_ctrl.md
Name: dds_phase_ctrl

Overview:
Sequencer for the quarter-wave sine DDS datapath. It replaces the free-running 6-bit address counter with a programmable phase accumulator. Per cycle it drives the quarter-wave LUT address, the mirror/negate controls and a sample-valid strobe, and it runs continuous or fixed-length tone bursts. Tuning-word (FTW) updates use a valid/ready handshake and are applied only at a period boundary, so frequency changes never glitch mid-period.

Parameters:
ACC_W, 16, phase accumulator width; top 8 bits are quadrant[1:0] + LUT index[5:0]
CNT_W, 8, burst period counter width

Ports:
clk  in  1  system clock, rising edge
rst  in  1  reset, asynchronous, active-low (0 = reset)
start  in  1  begin tone; accepted only in IDLE
stop  in  1  request graceful stop at next period boundary
burst_len  in  CNT_W  periods to play; sampled on accepted start; 0 = continuous
ftw_in  in  ACC_W  frequency tuning word
ftw_valid  in  1  ftw_in valid
ftw_ready  out  1  controller can accept ftw_in
lut_addr  out  6  quarter-wave LUT address
lut_neg  out  1  negate LUT output (quadrants 2,3)
lut_en  out  1  sample valid (state RUN)
period_tick  out  1  one-cycle pulse, accumulator wraps this cycle
busy  out  1  state RUN
done  out  1  one-cycle pulse after burst/stop completes

Behaviour:
- Reset (rst=0, async):
  - state=IDLE; acc=0; ftw_act=0; pend_valid=0; stop_pend=0; burst counter=0.
  - All outputs 0, except ftw_ready=1.
- States: IDLE, RUN. The RUN-to-IDLE edge sets done=1 for exactly the following cycle.
- IDLE:
  - acc held at 0; lut_en=0; lut_addr=0; lut_neg=0.
  - start=1: RUN next edge, acc=0, cnt<=burst_len, stop_pend<=0. A stop in the same cycle is ignored.
- RUN:
  - Each edge acc <= acc + ftw_act, modulo 2^ACC_W.
  - wrap = carry-out of acc + ftw_act, combinational; period_tick = wrap in RUN.
  - At a wrapping edge, in priority order:
    a) stop_pend=1, or (burst_len at start != 0 and cnt==1): go IDLE, acc<=0, stop_pend<=0, done next cycle.
    b) otherwise: if cnt != 0, cnt<=cnt-1; if pend_valid, ftw_act<=pend, pend_valid<=0.
  - stop=1 in RUN sets stop_pend; repeated stop is harmless.
  - ftw_act==0 in RUN never wraps: stop then takes effect at the next edge (IDLE, done pulse).
  - start in RUN is ignored.
- Quadrant decode, combinational from the acc register:
  - q=acc[ACC_W-1:ACC_W-2]; idx=acc[ACC_W-3:ACC_W-8].
  - q=0: addr=idx, neg=0
  - q=1: addr=63-idx, neg=0
  - q=2: addr=idx, neg=1
  - q=3: addr=63-idx, neg=1
  - Outputs forced to 0 in IDLE.
  - Zero address latency: lut_addr reflects current acc.
- FTW handshake:
  - ftw_ready = !pend_valid.
  - Transfer occurs when ftw_valid & ftw_ready.
  - In IDLE, a transfer writes ftw_act directly (pend stays empty).
  - In RUN, a transfer writes pend, pend_valid=1, and ready drops until the next wrap applies it.
  - Transfer and wrap in the same cycle: the wrap applies the old pend (none pending, since ready=1) and the new word lands in pend. It applies at the following wrap.
- Reset mid-burst: immediate IDLE; no done pulse; pending FTW discarded.

Decomposition:
- Package dds_pkg holds:
  - state encoding (IDLE, RUN)
  - LUT_AW=6
  - quadrant constants Q0..Q3
  - mirror function (63-idx)
- One sub-module, dds_quad_map: purely combinational acc top bits -> lut_addr, lut_neg. It is reused by the magnitude path.

Test Plan:
1) Continuous run:
   - Stimulus: ftw=0x0400 loaded in IDLE, start, burst_len=0.
   - Required: lut_addr 0,4,..,60 (q0), then 63,59,..,3 (q1, neg=0), then q2 repeats q0 with neg=1, then q3.
   - period_tick every 64 cycles.
2) Burst:
   - Stimulus: ftw=0x0400, burst_len=2, start at edge E0.
   - Required: lut_en high for exactly 128 cycles; period_tick at cycles 63 and 127; done one cycle after E128; busy low after it.
3) Glitch-free update:
   - Stimulus: in RUN at cycle 10, send ftw=0x0800.
   - Required: ftw_ready drops; step stays 4 until wrap at E64; step becomes 8; ready returns after E64.
4) Graceful stop:
   - Stimulus: stop at cycle 20 of a continuous run.
   - Required: RUN continues to the wrap at E64, then IDLE, acc=0, done pulse; outputs 0.
5) ftw=0 stop:
   - Stimulus: start with ftw_act=0, then stop.
   - Required: lut_addr constant 0 while running; IDLE and done on the edge after stop.
6) Async reset mid-burst:
   - Stimulus: rst low between clock edges with a pending FTW.
   - Required: outputs 0 immediately, ftw_ready=1, no done pulse, pending word lost.
